// File: rtl/imm_decode_if.sv
// imm_decode_if: fetch-side and execute-side handshake bundle for imm_decode_ctrl
//   slave  : seen by imm_decode_ctrl (takes in_*/flush/out_ready, drives the rest)
//   master : seen by the fetch/execute side
//   in_valid/in_ready/in_instr/in_pc : fetched instruction offer
//   flush                           : drop everything in flight
//   out_valid/out_ready/out_instr/out_pc : held decoded instruction
//   imm_sel/imm_in/illegal           : extender select, extender field, bad opcode
interface imm_decode_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  imm_sel;
  logic [24:0] imm_in;
  logic        illegal;
  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, imm_sel, imm_in, illegal
  );
  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, imm_sel, imm_in, illegal
  );
endinterface

// File: rtl/imm_decode_ctrl.sv
// imm_decode_ctrl: decode-stage sequencer with registered immediate select and optional skid entry
//   i_clk : rising-edge clock
//   i_rst : asynchronous active-high reset
//   bus   : imm_decode_if.slave (fetch handshake in, decoded instruction out, flush)
//   Build option DECODE_SKID_EN: adds a second (skid) entry and registers in_ready,
//   removing the combinational out_ready -> in_ready path.
module imm_decode_ctrl (
  input logic         i_clk,
  input logic         i_rst,
  imm_decode_if.slave bus
);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [1:0]  S_EMPTY = 2'd0;
  localparam logic [1:0]  S_ONE   = 2'd1;
  localparam logic [1:0]  S_TWO   = 2'd2;
`ifdef DECODE_SKID_EN
  localparam logic [1:0]  S_FULL  = S_TWO;
`else
  localparam logic [1:0]  S_FULL  = S_ONE;
`endif
  // {illegal, imm_sel}; every legal opcode ends in 2'b11, so a bad low pair falls to default
  function automatic logic [3:0] f_decode(input logic [31:0] instr);
    case (instr[6:0])
      7'b0110111, 7'b0010111:                         return 4'b0000;
      7'b1101111:                                     return 4'b0001;
      7'b1100011:                                     return 4'b0010;
      7'b0100011:                                     return 4'b0011;
      7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: return 4'b0100;
      7'b0010011:                                     return (instr[13:12] == 2'b01) ? 4'b0101 : 4'b0100;
      7'b0110011:                                     return 4'b0110;
      default:                                        return 4'b1110;
    endcase
  endfunction
  logic [1:0]  r_state;
  logic        r_out_valid;
  logic [31:0] r_out_instr;
  logic [31:0] r_out_pc;
  logic [2:0]  r_imm_sel;
  logic        r_illegal;
  logic        w_in_ready;
  logic        w_in;
  logic        w_out;
  logic        w_ld_head_in;
  logic        w_ld_head_skid;
  logic [1:0]  w_state_nxt;
  logic [3:0]  w_dec_in;
  logic [31:0] w_skid_instr;
  logic [31:0] w_skid_pc;
  logic [3:0]  w_skid_dec;
  assign w_in     = bus.in_valid && w_in_ready && !bus.flush;
  assign w_out    = r_out_valid && bus.out_ready;
  assign w_dec_in = f_decode(bus.in_instr);
  // head takes the new word when empty or when the head leaves in the same cycle
  assign w_ld_head_in   = w_in && (r_state == S_EMPTY || w_out);
  assign w_ld_head_skid = (r_state == S_TWO) && w_out;
  always_comb begin
    w_state_nxt = bus.flush ? S_EMPTY :
                  (r_state == S_EMPTY) ? (w_in ? S_ONE : S_EMPTY) :
                  (r_state == S_ONE)   ? ((w_in && !w_out) ? S_FULL : (w_out && !w_in) ? S_EMPTY : S_ONE) :
                  (w_out ? S_ONE : S_TWO);
  end
`ifdef DECODE_SKID_EN
  logic        r_in_ready;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic [3:0]  r_skid_dec;
  assign w_in_ready   = r_in_ready;
  assign w_skid_instr = r_skid_instr;
  assign w_skid_pc    = r_skid_pc;
  assign w_skid_dec   = r_skid_dec;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_in_ready <= 1'b1;
    else       r_in_ready <= (w_state_nxt != S_TWO);
  end
  always_ff @(posedge i_clk) begin
    if (w_in && r_state == S_ONE && !w_out) begin
      r_skid_instr <= bus.in_instr;
      r_skid_pc    <= bus.in_pc;
      r_skid_dec   <= w_dec_in;
    end
  end
`else
  assign w_in_ready   = !r_out_valid || bus.out_ready;
  assign w_skid_instr = NOP_INSTR;
  assign w_skid_pc    = 32'd0;
  assign w_skid_dec   = 4'b0100;
`endif
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_out_instr <= NOP_INSTR;
      r_out_pc    <= 32'd0;
      r_imm_sel   <= 3'b100;
      r_illegal   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != S_EMPTY);
      if (bus.flush) begin
        r_out_instr <= NOP_INSTR;
        r_imm_sel   <= 3'b100;
        r_illegal   <= 1'b0;
      end else if (w_ld_head_in) begin
        r_out_instr <= bus.in_instr;
        r_out_pc    <= bus.in_pc;
        r_imm_sel   <= w_dec_in[2:0];
        r_illegal   <= w_dec_in[3];
      end else if (w_ld_head_skid) begin
        r_out_instr <= w_skid_instr;
        r_out_pc    <= w_skid_pc;
        r_imm_sel   <= w_skid_dec[2:0];
        r_illegal   <= w_skid_dec[3];
      end
    end
  end
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_instr = r_out_instr;
  assign bus.out_pc    = r_out_pc;
  assign bus.imm_sel   = r_imm_sel;
  assign bus.imm_in    = r_out_instr[31:7];
  assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_imm_decode_ctrl.sv
// tb_imm_decode_ctrl: scoreboard bench for imm_decode_ctrl
module tb_imm_decode_ctrl;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  sel;
    logic        ill;
    int          cyc;
  } entry_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pops = 0;
  bit lat_chk = 0;
  entry_t q[$];
  imm_decode_if bus();
  imm_decode_ctrl dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    entry_t e;
    cyc++;
    if (!rst && bus.out_valid && bus.out_ready) begin
      pops++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got instr %h expected none", bus.out_instr);
      end else begin
        e = q.pop_front();
        chk("out_instr", 64'(bus.out_instr), 64'(e.instr));
        chk("out_pc", 64'(bus.out_pc), 64'(e.pc));
        chk("imm_sel", 64'(bus.imm_sel), 64'(e.sel));
        chk("illegal", 64'(bus.illegal), 64'(e.ill));
        chk("imm_in", 64'(bus.imm_in), 64'(e.instr[31:7]));
        if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'd1);
      end
    end
  end
  task automatic sync();
    @(posedge clk);
    #1;
  endtask
  // must be called just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [2:0] sel, input logic ill);
    bit acc = 0;
    entry_t e;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = bus.in_ready && !bus.flush;
      @(posedge clk);
      if (acc) begin
        e.instr = instr; e.pc = pc; e.sel = sel; e.ill = ill; e.cyc = cyc;
        q.push_back(e);
      end
    end
    #1;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept for %h expected accept within 50 cycles", instr);
    end
  endtask
  task automatic drain(input string name);
    bus.in_valid = 1'b0;
    repeat (3) sync();
    chk(name, 64'(q.size()), 64'd0);
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.in_instr = 32'd0; bus.in_pc = 32'd0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_instr", 64'(bus.out_instr), 64'h13);
    chk("rst_out_pc", 64'(bus.out_pc), 64'd0);
    chk("rst_imm_sel", 64'(bus.imm_sel), 64'd4);
    chk("rst_imm_in", 64'(bus.imm_in), 64'd0);
    chk("rst_illegal", 64'(bus.illegal), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    sync();
    lat_chk = 1;
    send(32'h000002B7, 32'h100, 3'b000, 1'b0);
    send(32'h008000EF, 32'h104, 3'b001, 1'b0);
    send(32'h00208463, 32'h108, 3'b010, 1'b0);
    send(32'h00112023, 32'h10C, 3'b011, 1'b0);
    send(32'h00102083, 32'h110, 3'b100, 1'b0);
    send(32'h00509093, 32'h114, 3'b101, 1'b0);
    send(32'h02208033, 32'h118, 3'b110, 1'b0);
    send(32'h0000007F, 32'h11C, 3'b110, 1'b1);
    send(32'h00000017, 32'h120, 3'b000, 1'b0);
    send(32'h000080E7, 32'h124, 3'b100, 1'b0);
    send(32'h4010D093, 32'h128, 3'b101, 1'b0);
    send(32'h00100093, 32'h12C, 3'b100, 1'b0);
    send(32'h00000073, 32'h130, 3'b100, 1'b0);
    send(32'h0000000F, 32'h134, 3'b100, 1'b0);
    send(32'h00000010, 32'h138, 3'b110, 1'b1);
    drain("stream_drain");
    chk("stream_pops", 64'(pops), 64'd15);
    lat_chk = 0;
    bus.out_ready = 1'b0;
    fork
      begin
        send(32'h00A00113, 32'h200, 3'b100, 1'b0);
        send(32'h00C00193, 32'h204, 3'b100, 1'b0);
        send(32'h00E00213, 32'h208, 3'b100, 1'b0);
        send(32'h00310233, 32'h20C, 3'b110, 1'b0);
      end
      begin
        @(negedge clk);
        chk("bp_ready_0", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
`ifdef DECODE_SKID_EN
        chk("bp_ready_1", 64'(bus.in_ready), 64'd1);
`else
        chk("bp_ready_1", 64'(bus.in_ready), 64'd0);
`endif
        chk("bp_hold_1", 64'(bus.out_instr), 64'h00A00113);
        @(negedge clk);
        chk("bp_ready_2", 64'(bus.in_ready), 64'd0);
        chk("bp_hold_2", 64'(bus.out_instr), 64'h00A00113);
        sync();
        bus.out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    chk("bp_pops", 64'(pops), 64'd19);
    bus.out_ready = 1'b0;
    send(32'h00100293, 32'h300, 3'b100, 1'b0);
`ifdef DECODE_SKID_EN
    send(32'h00200313, 32'h304, 3'b100, 1'b0);
`endif
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00300393;
    bus.in_pc = 32'h308;
    bus.flush = 1'b1;
    q.delete();
    sync();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_out_instr", 64'(bus.out_instr), 64'h13);
    chk("fl_imm_sel", 64'(bus.imm_sel), 64'd4);
    chk("fl_illegal", 64'(bus.illegal), 64'd0);
    chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
    sync();
    bus.out_ready = 1'b1;
    repeat (3) sync();
    chk("fl_no_output", 64'(pops), 64'd19);
    bus.out_ready = 1'b0;
    send(32'h00400413, 32'h400, 3'b100, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rs_pre_valid", 64'(bus.out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rs_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rs_out_instr", 64'(bus.out_instr), 64'h13);
    chk("rs_out_pc", 64'(bus.out_pc), 64'd0);
    chk("rs_imm_sel", 64'(bus.imm_sel), 64'd4);
    chk("rs_in_ready", 64'(bus.in_ready), 64'd1);
    q.delete();
    sync();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    lat_chk = 1;
    send(32'h00001537, 32'h500, 3'b000, 1'b0);
    send(32'h00A50023, 32'h504, 3'b011, 1'b0);
    drain("rs_drain");
    chk("rs_pops", 64'(pops), 64'd21);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imm_decode_ctrl.md
# imm_decode_ctrl

Decode-stage sequencer between the fetch unit and the immediate extender/register-read logic of the RV32IM core. It accepts fetched instructions over a valid/ready handshake, classifies the opcode, and presents a registered instruction, its PC, the extender select code and the extender input field. A two-entry skid buffer decouples back-pressure from the execute stage. FLUSH drops everything in flight on a taken branch or jump.

## Interface
- NOP_INSTR, 32'h0000_0013, value held on OUT_INSTR after reset or flush (ADDI x0,x0,0).
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  fetch offers IN_INSTR/IN_PC.
- IN_READY  out  1  block can accept this cycle.
- IN_INSTR  in  32  fetched instruction word.
- IN_PC  in  32  PC of IN_INSTR.
- FLUSH  in  1  discard all held and incoming instructions.
- OUT_VALID  out  1  OUT_* holds a valid decoded instruction.
- OUT_READY  in  1  execute stage consumes this cycle.
- OUT_INSTR  out  32  held instruction.
- OUT_PC  out  32  held PC.
- IMM_SEL  out  3  immediate-extender select code.
- IMM_IN  out  25  OUT_INSTR[31:7], wired to the extender input.
- ILLEGAL  out  1  held opcode is not RV32IM.

## Operation
- Transfer in: IN_VALID && IN_READY && !FLUSH. Transfer out: OUT_VALID && OUT_READY.
- Storage: output register (head) plus one skid entry. Order strictly FIFO.
- Decode on entry (opcode = instr[6:0]); result stored with the entry:
  - 0110111 LUI, 0010111 AUIPC -> 000 (U).
  - 1101111 JAL -> 001 (J).
  - 1100011 branch -> 010 (B).
  - 0100011 store -> 011 (S).
  - 0000011 load, 1100111 JALR, 0001111 FENCE, 1110011 SYSTEM -> 100 (I).
  - 0010011 OP-IMM: funct3 001 or 101 -> 101 (shift); else 100.
  - 0110011 OP (incl. M) -> 110 (no immediate; extender outputs 0).
  - any other opcode, or instr[1:0] != 2'b11 -> 110, ILLEGAL=1.
- States (occupancy): EMPTY, ONE (head valid), TWO (head + skid).
  - EMPTY: in -> ONE.
  - ONE: in && !out -> TWO; out && !in -> EMPTY; in && out -> ONE (new word to head).
  - TWO: out -> ONE (skid moves to head); IN_READY=0, no in.
- FLUSH (any state): next state EMPTY, OUT_INSTR=NOP_INSTR, IMM_SEL=100, ILLEGAL=0; same-cycle input dropped; same-cycle OUT_READY handshake still counts as consumed.
- While OUT_VALID=1 && OUT_READY=0, all OUT_*, IMM_SEL, IMM_IN, ILLEGAL hold stable.
- Reset values: OUT_VALID 0, OUT_INSTR NOP_INSTR, OUT_PC 0, IMM_SEL 100, IMM_IN NOP_INSTR[31:7], ILLEGAL 0, IN_READY 1, state EMPTY.

## Timing
- Latency: accepted word appears on OUT_* the next cycle (1 cycle).
- Throughput: one instruction per cycle with OUT_READY held high.
- All outputs registered except IN_READY (see Configuration); IMM_SEL/IMM_IN are registered decode results, so the extender gets a full cycle.
- RST asserted mid-operation: outputs go to reset values immediately, asynchronously; held instructions are lost.

## Configuration
- DECODE_SKID_EN defined: skid entry present; IN_READY is a flop equal to (state != TWO) for the next cycle; no combinational path OUT_READY -> IN_READY.
- Undefined: no skid entry, state TWO unreachable; IN_READY = !OUT_VALID || OUT_READY (combinational); same throughput, one less entry of buffering.

## Test plan
- Reset release, IN_VALID=0 -> OUT_VALID=0, OUT_INSTR=32'h00000013, IMM_SEL=100, IN_READY=1.
- Stream 0x000002B7 (LUI), 0x008000EF (JAL), 0x00208463 (BEQ), 0x00112023 (SW), 0x00102083 (LW), 0x00509093 (SLLI), 0x02208033 (MUL) with OUT_READY=1 -> one per cycle, IMM_SEL 000,001,010,011,100,101,110, ILLEGAL=0, 1-cycle latency.
- OUT_READY=0 for 3 cycles during stream -> with DECODE_SKID_EN, IN_READY drops one cycle after second accept; no loss, no duplication, order preserved.
- IN_INSTR=0x0000007F -> ILLEGAL=1, IMM_SEL=110.
- FLUSH in TWO with IN_VALID=1 -> next cycle OUT_VALID=0, OUT_INSTR=NOP_INSTR, input dropped, IN_READY=1.
- RST pulsed mid-stream with OUT_VALID=1 -> OUT_VALID=0 before next clock edge; stream resumes cleanly after release.
